// File: rtl/controller_pipe_pkg.sv
// Shared encodings and stage-control records for the pipelined controller.
// The illegal field exists only when CTRL_PIPE_TRAP_EN is defined.
package ctrl_pkg;

  localparam logic [6:0] OP_R     = 7'd51;
  localparam logic [6:0] OP_I     = 7'd19;
  localparam logic [6:0] OP_LW    = 7'd3;
  localparam logic [6:0] OP_SW    = 7'd35;
  localparam logic [6:0] OP_B     = 7'd99;
  localparam logic [6:0] OP_JAL   = 7'd111;
  localparam logic [6:0] OP_JALR  = 7'd103;
  localparam logic [6:0] OP_LUI   = 7'd55;
  localparam logic [6:0] OP_AUIPC = 7'd23;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  localparam int CTRL_ALU_W = 4;

  localparam logic [CTRL_ALU_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [CTRL_ALU_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [CTRL_ALU_W-1:0] ALU_AND  = 4'd2;
  localparam logic [CTRL_ALU_W-1:0] ALU_OR   = 4'd3;
  localparam logic [CTRL_ALU_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [CTRL_ALU_W-1:0] ALU_SLT  = 4'd5;
  localparam logic [CTRL_ALU_W-1:0] ALU_SLTU = 4'd6;
  localparam logic [CTRL_ALU_W-1:0] ALU_SLL  = 4'd7;
  localparam logic [CTRL_ALU_W-1:0] ALU_SRL  = 4'd8;
  localparam logic [CTRL_ALU_W-1:0] ALU_SRA  = 4'd9;

  typedef struct packed {
    logic                  reg_write;
    logic [1:0]            result_src;
    logic                  mem_write;
    logic                  jump;
    logic                  branch;
    logic                  jalr;
    logic                  alu_src_a;
    logic                  alu_src_b;
    logic [CTRL_ALU_W-1:0] alu_ctrl;
    logic [2:0]            funct3;
`ifdef CTRL_PIPE_TRAP_EN
    logic                  illegal;
`endif
  } e_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
`ifdef CTRL_PIPE_TRAP_EN
    logic       illegal;
`endif
  } m_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
`ifdef CTRL_PIPE_TRAP_EN
    logic       illegal;
`endif
  } w_ctrl_t;

  // funct3 010/011 are not branch encodings and never take.
  function automatic logic branch_cond(input logic [2:0] f3, input logic zero,
                                       input logic lt, input logic ltu);
    case (f3)
      3'b000:  return zero;
      3'b001:  return !zero;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return ltu;
      3'b111:  return !ltu;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/controller_pipe_if.sv
// Datapath <-> controller bundle. master = datapath side, slave = controller.
// illegal_w exists only when CTRL_PIPE_TRAP_EN is defined.
interface controller_pipe_if #(
  parameter int ALU_CTRL_W = 4,
  parameter int IMM_SRC_W  = 3
);
  logic [6:0]            opcode_d;
  logic [2:0]            funct3_d;
  logic                  funct7b5_d;
  logic                  en_e;
  logic                  flush_e;
  logic                  zero_e;
  logic                  lt_e;
  logic                  ltu_e;
  logic [IMM_SRC_W-1:0]  imm_src_d;
  logic                  alu_src_a_e;
  logic                  alu_src_b_e;
  logic [ALU_CTRL_W-1:0] alu_ctrl_e;
  logic                  pc_src_e;
  logic                  jalr_e;
  logic                  result_src_e0;
  logic                  reg_write_m;
  logic                  reg_write_w;
  logic                  mem_write_m;
  logic [1:0]            result_src_w;
`ifdef CTRL_PIPE_TRAP_EN
  logic                  illegal_w;
`endif

  modport master (
    output opcode_d, funct3_d, funct7b5_d, en_e, flush_e, zero_e, lt_e, ltu_e,
    input  imm_src_d, alu_src_a_e, alu_src_b_e, alu_ctrl_e, pc_src_e, jalr_e,
           result_src_e0, reg_write_m, reg_write_w, mem_write_m, result_src_w
`ifdef CTRL_PIPE_TRAP_EN
    , input illegal_w
`endif
  );

  modport slave (
    input  opcode_d, funct3_d, funct7b5_d, en_e, flush_e, zero_e, lt_e, ltu_e,
    output imm_src_d, alu_src_a_e, alu_src_b_e, alu_ctrl_e, pc_src_e, jalr_e,
           result_src_e0, reg_write_m, reg_write_w, mem_write_m, result_src_w
`ifdef CTRL_PIPE_TRAP_EN
    , output illegal_w
`endif
  );
endinterface

// File: rtl/controller_pipe_decode.sv
// Combinational D-stage main + ALU decoder. Unknown opcodes give an all-zero bubble;
// with CTRL_PIPE_TRAP_EN they and non-branch B funct3 values also set illegal.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output e_ctrl_t    ctrl_o,
  output logic [2:0] imm_src_o
);

  logic [CTRL_ALU_W-1:0] alu_ri;

  // funct7b5 only selects sub for R-type and sra/srai for both R and I.
  always_comb begin
    alu_ri = ALU_ADD;
    case (funct3_i)
      3'b000:  alu_ri = (opcode_i == OP_R && funct7b5_i) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_ri = ALU_SLL;
      3'b010:  alu_ri = ALU_SLT;
      3'b011:  alu_ri = ALU_SLTU;
      3'b100:  alu_ri = ALU_XOR;
      3'b101:  alu_ri = funct7b5_i ? ALU_SRA : ALU_SRL;
      3'b110:  alu_ri = ALU_OR;
      default: alu_ri = ALU_AND;
    endcase
  end

  always_comb begin
    ctrl_o    = '0;
    imm_src_o = IMM_I;
    case (opcode_i)
      OP_R: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_ctrl  = alu_ri;
      end
      OP_I: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src_b = 1'b1;
        ctrl_o.alu_ctrl  = alu_ri;
      end
      OP_LW: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.result_src = RES_MEM;
        ctrl_o.alu_src_b  = 1'b1;
      end
      OP_SW: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_src_b = 1'b1;
        imm_src_o        = IMM_S;
      end
      OP_B: begin
        ctrl_o.branch   = 1'b1;
        ctrl_o.alu_ctrl = ALU_SUB;
        ctrl_o.funct3   = funct3_i;
        imm_src_o       = IMM_B;
`ifdef CTRL_PIPE_TRAP_EN
        ctrl_o.illegal  = (funct3_i == 3'b010) || (funct3_i == 3'b011);
`endif
      end
      OP_JAL: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.result_src = RES_PC4;
        ctrl_o.jump       = 1'b1;
        imm_src_o         = IMM_J;
      end
      OP_JALR: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.result_src = RES_PC4;
        ctrl_o.jalr       = 1'b1;
        ctrl_o.alu_src_b  = 1'b1;
      end
      OP_LUI: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.result_src = RES_IMM;
        imm_src_o         = IMM_U;
      end
      OP_AUIPC: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = 1'b1;
        imm_src_o        = IMM_U;
      end
      default: begin
`ifdef CTRL_PIPE_TRAP_EN
        ctrl_o.illegal = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/controller_pipe.sv
// Pipelined controller: E/M/W control registers and E-stage branch resolution.
// Optional CTRL_PIPE_TRAP_EN carries an illegal-op bit to illegal_w.
module controller_pipe
  import ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 4,
  parameter int IMM_SRC_W  = 3
) (
  input  logic               clk,
  input  logic               reset,
  controller_pipe_if.slave   ctrl_if
);

  e_ctrl_t    dec_ctrl;
  logic [2:0] dec_imm_src;
  e_ctrl_t    e_q, e_d;
  m_ctrl_t    m_q, m_d;
  w_ctrl_t    w_q, w_d;

  ctrl_decode u_decode (
    .opcode_i   (ctrl_if.opcode_d),
    .funct3_i   (ctrl_if.funct3_d),
    .funct7b5_i (ctrl_if.funct7b5_d),
    .ctrl_o     (dec_ctrl),
    .imm_src_o  (dec_imm_src)
  );

  always_comb begin
    e_d = dec_ctrl;
    if (ctrl_if.flush_e)   e_d = '0;
    else if (!ctrl_if.en_e) e_d = e_q;
  end

  // A held E instruction has not advanced, so M takes a bubble; on a flush the
  // E instruction still moves on while E itself is cleared.
  always_comb begin
    m_d = '0;
    if (ctrl_if.en_e || ctrl_if.flush_e) begin
      m_d.reg_write  = e_q.reg_write;
      m_d.result_src = e_q.result_src;
      m_d.mem_write  = e_q.mem_write;
`ifdef CTRL_PIPE_TRAP_EN
      m_d.illegal    = e_q.illegal;
`endif
    end
  end

  always_comb begin
    w_d            = '0;
    w_d.reg_write  = m_q.reg_write;
    w_d.result_src = m_q.result_src;
`ifdef CTRL_PIPE_TRAP_EN
    w_d.illegal    = m_q.illegal;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  assign ctrl_if.imm_src_d     = IMM_SRC_W'(dec_imm_src);
  assign ctrl_if.alu_src_a_e   = e_q.alu_src_a;
  assign ctrl_if.alu_src_b_e   = e_q.alu_src_b;
  assign ctrl_if.alu_ctrl_e    = ALU_CTRL_W'(e_q.alu_ctrl);
  assign ctrl_if.jalr_e        = e_q.jalr;
  assign ctrl_if.result_src_e0 = e_q.result_src[0];
  assign ctrl_if.pc_src_e      = e_q.jump | e_q.jalr |
                                 (e_q.branch & branch_cond(e_q.funct3, ctrl_if.zero_e,
                                                           ctrl_if.lt_e, ctrl_if.ltu_e));
  assign ctrl_if.reg_write_m   = m_q.reg_write;
  assign ctrl_if.mem_write_m   = m_q.mem_write;
  assign ctrl_if.reg_write_w   = w_q.reg_write;
  assign ctrl_if.result_src_w  = w_q.result_src;
`ifdef CTRL_PIPE_TRAP_EN
  assign ctrl_if.illegal_w     = w_q.illegal;
`endif

endmodule

// File: tb/tb_controller_pipe.sv
// Self-checking bench for controller_pipe: decode table, directed pipeline sequences,
// and random traffic against a stage-by-stage reference model.
module tb_controller_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  controller_pipe_if #(.ALU_CTRL_W(4), .IMM_SRC_W(3)) bus ();

  controller_pipe #(.ALU_CTRL_W(4), .IMM_SRC_W(3)) u_dut (
    .clk     (clk),
    .reset   (reset),
    .ctrl_if (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    bit       rw;
    bit [1:0] rs;
    bit       mw;
    bit       jump;
    bit       branch;
    bit       jalr;
    bit       srca;
    bit       srcb;
    int       alu;
    bit [2:0] f3;
    bit       ill;
  } ctl_t;

  // ALU code by funct3 before funct7b5 adjustment: add sll slt sltu xor srl or and
  localparam int ALU_BASE[8] = '{0, 7, 5, 6, 4, 8, 3, 2};

  function automatic ctl_t ref_decode(bit [6:0] op, bit [2:0] f3, bit f7);
    ctl_t c = '{default: 0};
    case (op)
      7'd51:  begin c.rw = 1; c.alu = ALU_BASE[f3] + ((f7 && (f3 == 0 || f3 == 5)) ? 1 : 0); end
      7'd19:  begin c.rw = 1; c.srcb = 1; c.alu = ALU_BASE[f3] + ((f7 && f3 == 5) ? 1 : 0); end
      7'd3:   begin c.rw = 1; c.rs = 1; c.srcb = 1; end
      7'd35:  begin c.mw = 1; c.srcb = 1; end
      7'd99:  begin c.branch = 1; c.alu = 1; c.f3 = f3; c.ill = (f3 == 2 || f3 == 3); end
      7'd111: begin c.rw = 1; c.rs = 2; c.jump = 1; end
      7'd103: begin c.rw = 1; c.rs = 2; c.jalr = 1; c.srcb = 1; end
      7'd55:  begin c.rw = 1; c.rs = 3; end
      7'd23:  begin c.rw = 1; c.srca = 1; c.srcb = 1; end
      default: c.ill = 1;
    endcase
    return c;
  endfunction

  function automatic int imm_ref(bit [6:0] op);
    case (op)
      7'd35:         return 1;
      7'd99:         return 2;
      7'd111:        return 3;
      7'd55, 7'd23:  return 4;
      default:       return 0;
    endcase
  endfunction

  function automatic bit pc_ref(ctl_t e, bit z, bit lt, bit ltu);
    bit cond;
    case (e.f3)
      0: cond = z;   1: cond = !z;
      4: cond = lt;  5: cond = !lt;
      6: cond = ltu; 7: cond = !ltu;
      default: cond = 0;
    endcase
    return e.jump || e.jalr || (e.branch && cond);
  endfunction

  ctl_t e_m, m_m, w_m;
  ctl_t bubble = '{default: 0};

  task automatic check_model(input string tag);
    if (bus.opcode_d != 7'd51)
      chk({tag, ".imm_src_d"}, 32'(bus.imm_src_d), imm_ref(bus.opcode_d));
    chk({tag, ".alu_src_a_e"}, 32'(bus.alu_src_a_e), 32'(e_m.srca));
    chk({tag, ".alu_src_b_e"}, 32'(bus.alu_src_b_e), 32'(e_m.srcb));
    chk({tag, ".alu_ctrl_e"}, 32'(bus.alu_ctrl_e), e_m.alu);
    chk({tag, ".jalr_e"}, 32'(bus.jalr_e), 32'(e_m.jalr));
    chk({tag, ".result_src_e0"}, 32'(bus.result_src_e0), 32'(e_m.rs[0]));
    chk({tag, ".pc_src_e"}, 32'(bus.pc_src_e), 32'(pc_ref(e_m, bus.zero_e, bus.lt_e, bus.ltu_e)));
    chk({tag, ".reg_write_m"}, 32'(bus.reg_write_m), 32'(m_m.rw));
    chk({tag, ".mem_write_m"}, 32'(bus.mem_write_m), 32'(m_m.mw));
    chk({tag, ".reg_write_w"}, 32'(bus.reg_write_w), 32'(w_m.rw));
    chk({tag, ".result_src_w"}, 32'(bus.result_src_w), 32'(w_m.rs));
`ifdef CTRL_PIPE_TRAP_EN
    chk({tag, ".illegal_w"}, 32'(bus.illegal_w), 32'(w_m.ill));
`endif
  endtask

  // One clock: drive D inputs and flags, check, clock, advance the model.
  task automatic cycle(input string tag, input bit [6:0] op, input bit [2:0] f3, input bit f7,
                       input bit en, input bit fl, input bit [2:0] flags, input bit rst);
    bus.opcode_d = op; bus.funct3_d = f3; bus.funct7b5_d = f7;
    bus.en_e = en; bus.flush_e = fl;
    {bus.zero_e, bus.lt_e, bus.ltu_e} = flags;
    reset = rst;
    #1;
    check_model(tag);
    @(posedge clk);
    if (rst) begin
      e_m = bubble; m_m = bubble; w_m = bubble;
    end else begin
      w_m = m_m;
      m_m = (en || fl) ? e_m : bubble;
      if (fl)      e_m = bubble;
      else if (en) e_m = ref_decode(op, f3, f7);
    end
    @(negedge clk);
  endtask

  typedef struct {
    bit [6:0] op; bit [2:0] f3; bit f7;
    int imm; int alu; bit srca; bit srcb; bit rs0; bit jalr;
  } vec_t;

  vec_t vt[$];
  bit [6:0] ops[9] = '{7'd51, 7'd19, 7'd3, 7'd35, 7'd99, 7'd111, 7'd103, 7'd55, 7'd23};

  initial begin
    // imm = -1 marks R-type, which has no immediate
    vt.push_back('{7'd51, 3'd0, 1'b0, -1, 0, 0, 0, 0, 0});
    vt.push_back('{7'd51, 3'd0, 1'b1, -1, 1, 0, 0, 0, 0});
    vt.push_back('{7'd51, 3'd7, 1'b0, -1, 2, 0, 0, 0, 0});
    vt.push_back('{7'd51, 3'd6, 1'b0, -1, 3, 0, 0, 0, 0});
    vt.push_back('{7'd51, 3'd4, 1'b0, -1, 4, 0, 0, 0, 0});
    vt.push_back('{7'd51, 3'd2, 1'b0, -1, 5, 0, 0, 0, 0});
    vt.push_back('{7'd51, 3'd3, 1'b0, -1, 6, 0, 0, 0, 0});
    vt.push_back('{7'd51, 3'd1, 1'b0, -1, 7, 0, 0, 0, 0});
    vt.push_back('{7'd51, 3'd5, 1'b0, -1, 8, 0, 0, 0, 0});
    vt.push_back('{7'd51, 3'd5, 1'b1, -1, 9, 0, 0, 0, 0});
    vt.push_back('{7'd19, 3'd0, 1'b1,  0, 0, 0, 1, 0, 0});
    vt.push_back('{7'd19, 3'd5, 1'b1,  0, 9, 0, 1, 0, 0});
    vt.push_back('{7'd19, 3'd4, 1'b1,  0, 4, 0, 1, 0, 0});
    vt.push_back('{7'd3,  3'd2, 1'b0,  0, 0, 0, 1, 1, 0});
    vt.push_back('{7'd35, 3'd2, 1'b0,  1, 0, 0, 1, 0, 0});
    vt.push_back('{7'd99, 3'd0, 1'b0,  2, 1, 0, 0, 0, 0});
    vt.push_back('{7'd103,3'd0, 1'b0,  0, 0, 0, 1, 0, 1});
    vt.push_back('{7'd23, 3'd0, 1'b0,  4, 0, 1, 1, 0, 0});

    reset = 1'b1;
    bus.opcode_d = '0; bus.funct3_d = '0; bus.funct7b5_d = 1'b0;
    bus.en_e = 1'b1; bus.flush_e = 1'b0;
    bus.zero_e = 1'b0; bus.lt_e = 1'b0; bus.ltu_e = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    e_m = bubble; m_m = bubble; w_m = bubble;
    chk("rst.pc_src_e", 32'(bus.pc_src_e), 0);
    chk("rst.mem_write_m", 32'(bus.mem_write_m), 0);
    chk("rst.reg_write_w", 32'(bus.reg_write_w), 0);
    chk("rst.result_src_w", 32'(bus.result_src_w), 0);
    chk("rst.alu_ctrl_e", 32'(bus.alu_ctrl_e), 0);

    foreach (vt[i]) begin
      cycle("tbl", vt[i].op, vt[i].f3, vt[i].f7, 1, 0, 3'b000, 0);
      if (vt[i].imm >= 0) chk($sformatf("tbl%0d.imm_src_d", i), 32'(bus.imm_src_d), vt[i].imm);
      chk($sformatf("tbl%0d.alu_ctrl_e", i), 32'(bus.alu_ctrl_e), vt[i].alu);
      chk($sformatf("tbl%0d.alu_src_a_e", i), 32'(bus.alu_src_a_e), 32'(vt[i].srca));
      chk($sformatf("tbl%0d.alu_src_b_e", i), 32'(bus.alu_src_b_e), 32'(vt[i].srcb));
      chk($sformatf("tbl%0d.result_src_e0", i), 32'(bus.result_src_e0), 32'(vt[i].rs0));
      chk($sformatf("tbl%0d.jalr_e", i), 32'(bus.jalr_e), 32'(vt[i].jalr));
    end
    repeat (3) cycle("drain", 0, 0, 0, 1, 0, 3'b000, 0);

    // lw latency through E and W
    cycle("lw", 7'd3, 3'd2, 0, 1, 0, 3'b000, 0);
    chk("lw.alu_ctrl_e", 32'(bus.alu_ctrl_e), 0);
    chk("lw.result_src_e0", 32'(bus.result_src_e0), 1);
    cycle("lw", 0, 0, 0, 1, 0, 3'b000, 0);
    cycle("lw", 0, 0, 0, 1, 0, 3'b000, 0);
    chk("lw.reg_write_w", 32'(bus.reg_write_w), 1);
    chk("lw.result_src_w", 32'(bus.result_src_w), 1);

    // branch resolution
    cycle("beq", 7'd99, 3'd0, 0, 1, 0, 3'b100, 0);
    chk("beq_taken.pc_src_e", 32'(bus.pc_src_e), 1);
    bus.zero_e = 1'b0; #1;
    chk("beq_not.pc_src_e", 32'(bus.pc_src_e), 0);
    cycle("bltu", 7'd99, 3'd6, 0, 1, 0, 3'b001, 0);
    chk("bltu.pc_src_e", 32'(bus.pc_src_e), 1);
    cycle("bge", 7'd99, 3'd5, 0, 1, 0, 3'b010, 0);
    chk("bge_lt.pc_src_e", 32'(bus.pc_src_e), 0);
    cycle("b010", 7'd99, 3'd2, 0, 1, 0, 3'b111, 0);
    chk("b010.pc_src_e", 32'(bus.pc_src_e), 0);

    // flush on the load edge, alone and together with stall
    cycle("swfl", 7'd35, 3'd2, 0, 1, 1, 3'b000, 0);
    chk("swfl.alu_src_b_e", 32'(bus.alu_src_b_e), 0);
    cycle("swfl", 0, 0, 0, 1, 0, 3'b000, 0);
    chk("swfl.mem_write_m", 32'(bus.mem_write_m), 0);
    cycle("swfl2", 7'd35, 3'd2, 0, 1, 0, 3'b000, 0);
    cycle("swfl2", 7'd35, 3'd2, 0, 0, 1, 3'b000, 0);
    chk("swfl2.alu_src_b_e", 32'(bus.alu_src_b_e), 0);

    // stall holds sub in E; it then passes through M and W exactly once
    cycle("sub", 7'd51, 3'd0, 1, 1, 0, 3'b000, 0);
    chk("sub.alu_ctrl_e", 32'(bus.alu_ctrl_e), 1);
    for (int k = 0; k < 2; k++) begin
      cycle("hold", 0, 0, 0, 0, 0, 3'b000, 0);
      chk($sformatf("hold%0d.alu_ctrl_e", k), 32'(bus.alu_ctrl_e), 1);
      chk($sformatf("hold%0d.reg_write_m", k), 32'(bus.reg_write_m), 0);
    end
    cycle("rel", 0, 0, 0, 1, 0, 3'b000, 0);
    chk("rel.reg_write_m", 32'(bus.reg_write_m), 1);
    cycle("rel", 0, 0, 0, 1, 0, 3'b000, 0);
    chk("rel2.reg_write_m", 32'(bus.reg_write_m), 0);
    chk("rel2.reg_write_w", 32'(bus.reg_write_w), 1);
    cycle("rel", 0, 0, 0, 1, 0, 3'b000, 0);
    chk("rel3.reg_write_w", 32'(bus.reg_write_w), 0);

    // lui then jalr
    cycle("lui", 7'd55, 0, 0, 1, 0, 3'b000, 0);
    cycle("jalr", 7'd103, 0, 0, 1, 0, 3'b000, 0);
    chk("jalr.jalr_e", 32'(bus.jalr_e), 1);
    chk("jalr.pc_src_e", 32'(bus.pc_src_e), 1);
    cycle("lj", 0, 0, 0, 1, 0, 3'b000, 0);
    chk("lui.result_src_w", 32'(bus.result_src_w), 3);
    cycle("lj", 0, 0, 0, 1, 0, 3'b000, 0);
    chk("jalr.result_src_w", 32'(bus.result_src_w), 2);

    // reset with sw in M and jal in E
    cycle("rmid", 7'd35, 3'd2, 0, 1, 0, 3'b000, 0);
    cycle("rmid", 7'd111, 0, 0, 1, 0, 3'b000, 0);
    chk("rmid.mem_write_m_pre", 32'(bus.mem_write_m), 1);
    chk("rmid.pc_src_e_pre", 32'(bus.pc_src_e), 1);
    cycle("rmid", 0, 0, 0, 1, 0, 3'b000, 1);
    chk("rmid.mem_write_m", 32'(bus.mem_write_m), 0);
    chk("rmid.pc_src_e", 32'(bus.pc_src_e), 0);
    chk("rmid.reg_write_w", 32'(bus.reg_write_w), 0);

`ifdef CTRL_PIPE_TRAP_EN
    cycle("trap", 7'h7F, 0, 0, 1, 0, 3'b000, 0);
    cycle("trap", 0, 0, 0, 1, 0, 3'b000, 0);
    cycle("trap", 7'd51, 0, 0, 1, 0, 3'b000, 0);
    chk("trap.illegal_w", 32'(bus.illegal_w), 1);
    chk("trap.reg_write_w", 32'(bus.reg_write_w), 0);
    cycle("trap", 0, 0, 0, 1, 0, 3'b000, 0);
    chk("trap_next.illegal_w", 32'(bus.illegal_w), 0);
    cycle("trapfl", 7'h7F, 0, 0, 1, 1, 3'b000, 0);
    repeat (2) cycle("trapfl", 0, 0, 0, 1, 0, 3'b000, 0);
    chk("trapfl.illegal_w", 32'(bus.illegal_w), 0);
`endif

    for (int n = 0; n < 400; n++) begin
      int idx = $urandom_range(0, 9);
      bit [6:0] op = (idx == 9) ? 7'($urandom) : ops[idx];
      cycle("rnd", op, 3'($urandom), 1'($urandom), ($urandom_range(0, 9) < 8),
            ($urandom_range(0, 9) == 0), 3'($urandom), ($urandom_range(0, 39) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
